// File: rtl/cve2_mem_responder.sv
// Far-end bus responder: word array behind a fixed-latency, in-order response pipeline.
// Define CVE2_MEM_RESP_STALL_EN to add LFSR-driven grant stalls for requester wait-path coverage.
module cve2_mem_responder #(
    parameter int unsigned MemWords       = 1024,
    parameter logic [31:0] AddrBase       = 32'h0000_0000,
    parameter int unsigned Latency        = 1,
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    output logic        gnt_o,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] wdata_i,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);
    localparam int unsigned IdxW = (MemWords > 1) ? $clog2(MemWords) : 1;
    localparam logic [32:0] Span = 33'(MemWords) << 2;

    if (MemWords < 2 || (MemWords & (MemWords - 1)) != 0) begin : g_bad_words
        $error("MemWords must be a power of two >= 2");
    end
    if (({1'b0, AddrBase} & (Span - 33'd1)) != '0) begin : g_bad_base
        $error("AddrBase must be aligned to 4*MemWords");
    end
    if (Latency < 1 || Latency > 8) begin : g_bad_lat
        $error("Latency must be in 1..8");
    end
    if (MaxOutstanding < 1 || MaxOutstanding > Latency) begin : g_bad_out
        $error("MaxOutstanding must be in 1..Latency");
    end

    typedef struct packed {
        logic        valid;
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    logic [31:0]     offset;
    logic            in_range;
    logic [IdxW-1:0] idx;
    logic            accept;
    logic            retire;
    logic            stall;
    logic [3:0]      count_q;
    logic [3:0]      inflight_q;
    resp_t           resp_in;
    resp_t           pipe_q [Latency];
    logic [31:0]     mem [MemWords];

    assign offset   = addr_i - AddrBase;
    assign in_range = (addr_i >= AddrBase) && ({1'b0, offset} < Span);
    assign idx      = offset[IdxW+1:2];

    assign gnt_o  = req_i && !rst_i && (count_q < 4'(MaxOutstanding)) && !stall;
    assign accept = gnt_o;

    // Read data is captured at the accept edge; the write below lands on the same edge.
    always_comb begin
        resp_in       = '0;
        resp_in.valid = accept;
        resp_in.err   = accept && !in_range;
        if (accept && !we_i && in_range) resp_in.rdata = mem[idx];
    end

    always_ff @(posedge clk_i) begin
        if (accept && we_i && in_range) begin
            for (int k = 0; k < 4; k++) begin
                if (be_i[k]) mem[idx][8*k +: 8] <= wdata_i[8*k +: 8];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int s = 0; s < Latency; s++) pipe_q[s] <= '0;
        end else begin
            pipe_q[0] <= resp_in;
            for (int s = 1; s < Latency; s++) pipe_q[s] <= pipe_q[s-1];
        end
    end

    assign rvalid_o = pipe_q[Latency-1].valid;
    assign rdata_o  = pipe_q[Latency-1].rdata;
    assign err_o    = pipe_q[Latency-1].err;

    // A slot frees on the edge that loads the output stage, so gnt_o rises
    // in the same cycle the oldest rvalid_o is driven.
    if (Latency == 1) begin : g_retire_direct
        assign retire = accept;
    end else begin : g_retire_pipe
        assign retire = pipe_q[Latency-2].valid;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            case ({accept, retire})
                2'b10:   count_q <= count_q + 4'd1;
                2'b01:   count_q <= count_q - 4'd1;
                default: count_q <= count_q;
            endcase
        end
    end

`ifdef CVE2_MEM_RESP_STALL_EN
    logic [15:0] lfsr_q;
    always_ff @(posedge clk_i) begin
        if (rst_i) lfsr_q <= 16'hACE1;
        else       lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
    assign stall = (lfsr_q[1:0] == 2'b00);
`else
    assign stall = 1'b0;
`endif

    // Granted-but-unanswered tracker, used only to qualify rvalid_o.
    always_ff @(posedge clk_i) begin
        if (rst_i) inflight_q <= '0;
        else       inflight_q <= inflight_q + 4'(accept) - 4'(rvalid_o);
    end

    a_count_max: assert property (@(posedge clk_i) disable iff (rst_i)
        count_q <= 4'(MaxOutstanding));
    a_count_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
        !(retire && !accept && count_q == '0));
    a_rvalid_matched: assert property (@(posedge clk_i) disable iff (rst_i)
        rvalid_o |-> inflight_q != '0);

endmodule

// File: tb/tb_cve2_mem_responder.sv
// Directed bench for cve2_mem_responder: three instances cover Latency 1, 4 (MaxOutstanding 2) and 3.
// With CVE2_MEM_RESP_STALL_EN defined, a random run checks LFSR grant stalls and in-order data.
module tb_cve2_mem_responder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1, rst_c_x = 1'b0;
    logic        req_a = 1'b0, req_b = 1'b0, req_c = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = '0, wdata = '0;
    logic [3:0]  be = '0;
    logic        gnt_a, rvalid_a, err_a, gnt_b, rvalid_b, err_b, gnt_c, rvalid_c, err_c;
    logic [31:0] rdata_a, rdata_b, rdata_c;
    int          n_chk = 0, n_err = 0;

    cve2_mem_responder #(.MemWords(64), .AddrBase(32'h0000_1000), .Latency(1), .MaxOutstanding(1)) u_dut_a (
        .clk_i(clk), .rst_i(rst), .req_i(req_a), .gnt_o(gnt_a), .addr_i(addr), .we_i(we),
        .be_i(be), .wdata_i(wdata), .rvalid_o(rvalid_a), .rdata_o(rdata_a), .err_o(err_a));
    cve2_mem_responder #(.MemWords(64), .AddrBase(32'h0000_0000), .Latency(4), .MaxOutstanding(2)) u_dut_b (
        .clk_i(clk), .rst_i(rst), .req_i(req_b), .gnt_o(gnt_b), .addr_i(addr), .we_i(we),
        .be_i(be), .wdata_i(wdata), .rvalid_o(rvalid_b), .rdata_o(rdata_b), .err_o(err_b));
    cve2_mem_responder #(.MemWords(64), .AddrBase(32'h0000_0000), .Latency(3), .MaxOutstanding(2)) u_dut_c (
        .clk_i(clk), .rst_i(rst | rst_c_x), .req_i(req_c), .gnt_o(gnt_c), .addr_i(addr), .we_i(we),
        .be_i(be), .wdata_i(wdata), .rvalid_o(rvalid_c), .rdata_o(rdata_c), .err_o(err_c));

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic drv(input logic w, input logic [31:0] a, input logic [3:0] b, input logic [31:0] d);
        we = w; addr = a; be = b; wdata = d;
    endtask

    // One back-to-back transfer on the Latency-1 instance; its response is checked the next cycle.
    task automatic xfer_a(input string tag, input logic w, input logic [31:0] a, input logic [3:0] b,
                          input logic [31:0] d, input logic [31:0] exp_rd, input logic exp_err);
        drv(w, a, b, d); req_a = 1'b1; #1;
        chk({tag, "_gnt"}, gnt_a, 1);
        cyc();
        chk({tag, "_rv"}, rvalid_a, 1);
        chk({tag, "_rd"}, rdata_a, exp_rd);
        chk({tag, "_err"}, err_a, exp_err);
    endtask

`ifdef CVE2_MEM_RESP_STALL_EN
    logic [15:0] m_lfsr;
    logic [31:0] m_mem [64];
    always @(posedge clk)
        m_lfsr <= rst ? 16'hACE1 : {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};

    task automatic rcyc(input logic r, input logic w, input logic [31:0] a, input logic [3:0] b,
                        input logic [31:0] d, output logic acc);
        logic        inr;
        logic [31:0] off, exp_d;
        int          wi;
        drv(w, a, b, d); req_a = r; #1;
        acc   = r && (m_lfsr[1:0] != 2'b00);
        off   = a - 32'h1000;
        wi    = int'(off[7:2]);
        inr   = (a >= 32'h1000) && (a < 32'h1100);
        exp_d = (acc && !w && inr) ? m_mem[wi] : 32'h0;
        chk("st_gnt", gnt_a, acc);
        if (acc && w && inr)
            for (int k = 0; k < 4; k++) if (b[k]) m_mem[wi][8*k +: 8] = d[8*k +: 8];
        cyc();
        chk("st_rv", rvalid_a, acc);
        chk("st_rd", rdata_a, exp_d);
        chk("st_err", err_a, acc && !inr);
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        bit exp_g [10] = '{1, 1, 0, 0, 1, 1, 0, 0, 1, 1};
        logic acc;

        // Reset: outputs idle, grant suppressed even with a request pending.
        req_a = 1'b1;
        repeat (2) cyc();
        chk("rst_gnt", gnt_a, 0);
        chk("rst_rv_a", rvalid_a, 0);
        chk("rst_rd_a", rdata_a, 0);
        chk("rst_err_a", err_a, 0);
        chk("rst_rv_b", rvalid_b, 0);
        chk("rst_rv_c", rvalid_c, 0);
        rst = 1'b0; req_a = 1'b0;

`ifdef CVE2_MEM_RESP_STALL_EN
        for (int w = 0; w < 64; w++) begin
            acc = 1'b0;
            for (int t = 0; t < 20 && !acc; t++)
                rcyc(1'b1, 1'b1, 32'h1000 + 32'(4 * w), 4'hF, $urandom, acc);
        end
        for (int i = 0; i < 1000; i++)
            rcyc($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 15) == 0) ? 32'h1100 : 32'h1000 + 32'(4 * $urandom_range(0, 63)),
                 4'($urandom_range(0, 15)), $urandom, acc);
        req_a = 1'b0;
`else
        // Write then read back at Latency 1.
        xfer_a("t1w", 1, 32'h1010, 4'hF, 32'hDEADBEEF, 32'h0, 0);
        xfer_a("t1r", 0, 32'h1010, 4'h0, 32'h0, 32'hDEADBEEF, 0);
        // Byte enables, including an all-zero mask.
        xfer_a("t2pre", 1, 32'h1020, 4'hF, 32'h11223344, 32'h0, 0);
        xfer_a("t2be", 1, 32'h1020, 4'b0101, 32'hAABBCCDD, 32'h0, 0);
        xfer_a("t2be0", 1, 32'h1020, 4'h0, 32'hFFFFFFFF, 32'h0, 0);
        xfer_a("t2r", 0, 32'h1020, 4'h0, 32'h0, 32'h11BB33DD, 0);
        // Out of range above and below; the high write would alias word 0 if not blocked.
        xfer_a("t3w0", 1, 32'h1000, 4'hF, 32'h5A5A0000, 32'h0, 0);
        xfer_a("t3hi_r", 0, 32'h1100, 4'h0, 32'h0, 32'h0, 1);
        xfer_a("t3lo_r", 0, 32'h0FFC, 4'h0, 32'h0, 32'h0, 1);
        xfer_a("t3hi_w", 1, 32'h1100, 4'hF, 32'hFFFFFFFF, 32'h0, 1);
        xfer_a("t3r0", 0, 32'h1000, 4'h0, 32'h0, 32'h5A5A0000, 0);
        req_a = 1'b0;
        cyc();
        chk("idle_rv", rvalid_a, 0);
        chk("idle_rd", rdata_a, 0);
        chk("idle_err", err_a, 0);

        // Backpressure at Latency 4, MaxOutstanding 2.
        drv(1, 32'h0, 4'hF, 32'h12345678); req_b = 1'b1;
        cyc();
        req_b = 1'b0;
        repeat (4) cyc();
        drv(0, 32'h0, 4'h0, 32'h0);
        for (int i = 0; i < 14; i++) begin
            req_b = (i < 10);
            #1;
            chk($sformatf("t4_gnt%0d", i), gnt_b, (i < 10) ? exp_g[i] : 1'b0);
            chk($sformatf("t4_rv%0d", i), rvalid_b, (i >= 4) ? exp_g[i-4] : 1'b0);
            chk($sformatf("t4_rd%0d", i), rdata_b, ((i >= 4) && exp_g[i-4]) ? 32'h12345678 : 32'h0);
            chk($sformatf("t4_err%0d", i), err_b, 0);
            chk($sformatf("t4_cnt%0d", i), u_dut_b.count_q <= 4'd2, 1);
            cyc();
        end
        req_b = 1'b0;

        // Reset mid-flight at Latency 3.
        drv(1, 32'h8, 4'hF, 32'hCAFEF00D); req_c = 1'b1; #1;
        chk("t5_wgnt", gnt_c, 1);
        cyc();
        req_c = 1'b0;
        repeat (3) cyc();
        drv(0, 32'h8, 4'h0, 32'h0); req_c = 1'b1; #1;
        chk("t5_gnt0", gnt_c, 1);
        cyc();
        chk("t5_gnt1", gnt_c, 1);
        cyc();
        req_c = 1'b0; rst_c_x = 1'b1;
        cyc();
        rst_c_x = 1'b0;
        chk("t5_rv3", rvalid_c, 0);
        chk("t5_cnt", u_dut_c.count_q, 0);
        req_c = 1'b1; #1;
        chk("t5_gnt3", gnt_c, 1);
        cyc();
        req_c = 1'b0;
        chk("t5_rv4", rvalid_c, 0);
        cyc();
        chk("t5_rv5", rvalid_c, 0);
        cyc();
        chk("t5_rv6", rvalid_c, 1);
        chk("t5_rd6", rdata_c, 32'hCAFEF00D);
        chk("t5_err6", err_c, 0);
`endif
        cyc();
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
